// File: rtl/note_field_ctrl.sv
// note_field_ctrl
// ---------------
// Note-field controller for the hand-tracking rhythm game. Holds up to
// NUM_SLOTS live target circles, ages them on the beat tick, judges hits
// from the left/right hand trackers and keeps score, combo and best combo.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   note_valid, note_x, note_y   one-cycle strobe presenting a new note
//   lifetime                     ticks a new note stays live (0 = forever)
//   tick                         beat strobe that ages live slots
//   hand_{l,r}_{valid,x,y}       raw hand tracker inputs
//   tolerance                    hit window half-width (strict compare)
//   slot_pos, slot_show          packed {x,y} per slot and live flags
//   hand_{l,r}_pos               mapped hand position, 0 when invalid
//   score, combo, max_combo      scoring state
//   hit_pulse, miss_pulse        one-cycle strobes for this cycle's events
module note_field_ctrl #(
    parameter int NUM_SLOTS  = 4,
    parameter int COORD_W    = 8,
    parameter int LIFE_W     = 8,
    parameter int SCORE_W    = 12,
    parameter int COMBO_W    = 8,
    parameter int HIT_POINTS = 5,
    parameter int Y_TOP      = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             note_valid,
    input  logic [COORD_W-1:0]               note_x,
    input  logic [COORD_W-1:0]               note_y,
    input  logic [LIFE_W-1:0]                lifetime,
    input  logic                             tick,
    input  logic                             hand_l_valid,
    input  logic                             hand_r_valid,
    input  logic [COORD_W-1:0]               hand_l_x,
    input  logic [COORD_W-1:0]               hand_l_y,
    input  logic [COORD_W-1:0]               hand_r_x,
    input  logic [COORD_W-1:0]               hand_r_y,
    input  logic [COORD_W-1:0]               tolerance,
    output logic [NUM_SLOTS*2*COORD_W-1:0]   slot_pos,
    output logic [NUM_SLOTS-1:0]             slot_show,
    output logic [2*COORD_W-1:0]             hand_l_pos,
    output logic [2*COORD_W-1:0]             hand_r_pos,
    output logic [SCORE_W-1:0]               score,
    output logic [COMBO_W-1:0]               combo,
    output logic [COMBO_W-1:0]               max_combo,
    output logic                             hit_pulse,
    output logic                             miss_pulse
);

    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int POS_W = 2 * COORD_W;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    localparam logic [31:0] SCORE_MAX = 32'({SCORE_W{1'b1}});
    localparam logic [31:0] COMBO_MAX = 32'({COMBO_W{1'b1}});

    logic [POS_W-1:0]   pos_q  [NUM_SLOTS];
    logic [POS_W-1:0]   pos_d  [NUM_SLOTS];
    logic [LIFE_W-1:0]  life_q [NUM_SLOTS];
    logic [LIFE_W-1:0]  life_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] show_q, show_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_combo_q, max_combo_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic [POS_W-1:0]   hand_l_pos_q, hand_l_pos_d;
    logic [POS_W-1:0]   hand_r_pos_q, hand_r_pos_d;

    logic [COORD_W-1:0] map_l_y, map_r_y;
    logic [NUM_SLOTS-1:0] hit;
    logic [CNT_W-1:0]   hit_cnt;
    logic               dup;
    logic               free_found;
    logic [PTR_W-1:0]   free_idx;
    logic [PTR_W-1:0]   tgt;
    logic               miss;
    logic [31:0]        score_sum;
    logic [31:0]        combo_base;

    // True unsigned distance; never wraps.
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Strict window, so tolerance 0 can never produce a hit.
    function automatic logic near(input logic [COORD_W-1:0] hx, input logic [COORD_W-1:0] hy,
                                  input logic [POS_W-1:0] sp, input logic [COORD_W-1:0] tol);
        return (abs_diff(hx, sp[POS_W-1:COORD_W]) < tol) && (abs_diff(hy, sp[COORD_W-1:0]) < tol);
    endfunction

    // Hand mapping flips y around Y_TOP; hit judging uses these unregistered values.
    always_comb begin
        map_l_y      = COORD_W'(Y_TOP) - hand_l_y;
        map_r_y      = COORD_W'(Y_TOP) - hand_r_y;
        hand_l_pos_d = hand_l_valid ? {hand_l_x, map_l_y} : '0;
        hand_r_pos_d = hand_r_valid ? {hand_r_x, map_r_y} : '0;
    end

    // Hit detection, duplicate check and lowest free slot search, all on registered slot state.
    always_comb begin
        hit        = '0;
        hit_cnt    = '0;
        dup        = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit[i] = show_q[i] &&
                     ((hand_l_valid && near(hand_l_x, map_l_y, pos_q[i], tolerance)) ||
                      (hand_r_valid && near(hand_r_x, map_r_y, pos_q[i], tolerance)));
            hit_cnt = hit_cnt + {{(CNT_W-1){1'b0}}, hit[i]};
            if (show_q[i] && (pos_q[i] == {note_x, note_y})) begin
                dup = 1'b1;
            end
        end
        // Descending scan so the lowest free index is the one left standing.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!show_q[i]) begin
                free_found = 1'b1;
                free_idx   = PTR_W'(i);
            end
        end
    end

    // Slot update: hit clears first, otherwise aging may expire; the insertion
    // write comes last so a new note lands on top of a hit or expiring slot.
    // Misses are a per-cycle flag, so an expiry plus overwrite on one slot is one miss.
    always_comb begin
        pos_d    = pos_q;
        life_d   = life_q;
        show_d   = show_q;
        rr_ptr_d = rr_ptr_q;
        miss     = 1'b0;
        tgt      = free_idx;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit[i]) begin
                show_d[i] = 1'b0;
            end else if (tick && show_q[i] && (life_q[i] != '0)) begin
                life_d[i] = life_q[i] - 1'b1;
                if (life_q[i] == LIFE_W'(1)) begin
                    show_d[i] = 1'b0;
                    miss      = 1'b1;
                end
            end
        end
        if (note_valid && !dup) begin
            if (!free_found) begin
                tgt      = rr_ptr_q;
                miss     = 1'b1;
                rr_ptr_d = (rr_ptr_q == PTR_W'(NUM_SLOTS - 1)) ? '0 : rr_ptr_q + 1'b1;
            end
            pos_d[tgt]  = {note_x, note_y};
            show_d[tgt] = 1'b1;
            life_d[tgt] = lifetime;
        end
    end

    // Saturating score and combo arithmetic done in 32 bits before clamping.
    always_comb begin
        score_sum    = 32'(score_q) + 32'(hit_cnt) * 32'(HIT_POINTS);
        score_d      = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
        combo_base   = miss ? 32'(hit_cnt) : 32'(combo_q) + 32'(hit_cnt);
        combo_d      = (combo_base > COMBO_MAX) ? '1 : combo_base[COMBO_W-1:0];
        max_combo_d  = (combo_d > max_combo_q) ? combo_d : max_combo_q;
        hit_pulse_d  = |hit;
        miss_pulse_d = miss;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pos_q[i]  <= '0;
                life_q[i] <= '0;
            end
            show_q       <= '0;
            rr_ptr_q     <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            max_combo_q  <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hand_l_pos_q <= '0;
            hand_r_pos_q <= '0;
        end else begin
            pos_q        <= pos_d;
            life_q       <= life_d;
            show_q       <= show_d;
            rr_ptr_q     <= rr_ptr_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            max_combo_q  <= max_combo_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hand_l_pos_q <= hand_l_pos_d;
            hand_r_pos_q <= hand_r_pos_d;
        end
    end

    always_comb begin
        slot_pos = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_pos[i*POS_W +: POS_W] = pos_q[i];
        end
    end

    assign slot_show  = show_q;
    assign hand_l_pos = hand_l_pos_q;
    assign hand_r_pos = hand_r_pos_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign max_combo  = max_combo_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_note_field_ctrl.sv
// tb_note_field_ctrl
// ------------------
// Directed bench for note_field_ctrl. A default-parameter instance carries the
// game sequence; a second instance with SCORE_W=4 sees the same inputs so its
// score shows saturation at 15. Expected outputs are queued per step and
// compared one cycle later.
module tb_note_field_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        note_valid;
    logic [7:0]  note_x, note_y;
    logic [7:0]  lifetime;
    logic        tick;
    logic        hand_l_valid, hand_r_valid;
    logic [7:0]  hand_l_x, hand_l_y, hand_r_x, hand_r_y;
    logic [7:0]  tolerance;

    logic [63:0] slot_pos;
    logic [3:0]  slot_show;
    logic [15:0] hand_l_pos, hand_r_pos;
    logic [11:0] score;
    logic [7:0]  combo, max_combo;
    logic        hit_pulse, miss_pulse;

    logic [63:0] s_slot_pos;
    logic [3:0]  s_slot_show;
    logic [15:0] s_hand_l_pos, s_hand_r_pos;
    logic [3:0]  s_score;
    logic [7:0]  s_combo, s_max_combo;
    logic        s_hit_pulse, s_miss_pulse;

    always #5 clk = ~clk;

    note_field_ctrl dut (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_x(note_x), .note_y(note_y),
        .lifetime(lifetime), .tick(tick), .hand_l_valid(hand_l_valid), .hand_r_valid(hand_r_valid),
        .hand_l_x(hand_l_x), .hand_l_y(hand_l_y), .hand_r_x(hand_r_x), .hand_r_y(hand_r_y),
        .tolerance(tolerance), .slot_pos(slot_pos), .slot_show(slot_show),
        .hand_l_pos(hand_l_pos), .hand_r_pos(hand_r_pos), .score(score), .combo(combo),
        .max_combo(max_combo), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    note_field_ctrl #(.SCORE_W(4)) dut_sat (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_x(note_x), .note_y(note_y),
        .lifetime(lifetime), .tick(tick), .hand_l_valid(hand_l_valid), .hand_r_valid(hand_r_valid),
        .hand_l_x(hand_l_x), .hand_l_y(hand_l_y), .hand_r_x(hand_r_x), .hand_r_y(hand_r_y),
        .tolerance(tolerance), .slot_pos(s_slot_pos), .slot_show(s_slot_show),
        .hand_l_pos(s_hand_l_pos), .hand_r_pos(s_hand_r_pos), .score(s_score), .combo(s_combo),
        .max_combo(s_max_combo), .hit_pulse(s_hit_pulse), .miss_pulse(s_miss_pulse)
    );

    typedef struct {
        string       tag;
        logic [3:0]  show;
        logic [11:0] score;
        logic [7:0]  combo;
        logic [7:0]  maxc;
        logic        hit;
        logic        miss;
        int          pidx;
        logic [15:0] pos;
        logic [15:0] hl;
        logic [15:0] hr;
        logic [3:0]  sat;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic exp_t mkExp(string tag, logic [3:0] show, int sc, int cb, int mc,
                                   bit hit, bit miss, int pidx, logic [15:0] pos,
                                   logic [15:0] hl, logic [15:0] hr, int sat);
        exp_t e;
        e.tag = tag; e.show = show; e.score = 12'(sc); e.combo = 8'(cb); e.maxc = 8'(mc);
        e.hit = hit; e.miss = miss; e.pidx = pidx; e.pos = pos; e.hl = hl; e.hr = hr;
        e.sat = 4'(sat);
        return e;
    endfunction

    task automatic cmp(string tag, string name, logic [31:0] obs, logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, expv);
        end
    endtask

    task automatic setIdle();
        rst = 1'b0; note_valid = 1'b0; note_x = '0; note_y = '0; tick = 1'b0;
        hand_l_valid = 1'b0; hand_r_valid = 1'b0;
        hand_l_x = '0; hand_l_y = '0; hand_r_x = '0; hand_r_y = '0;
    endtask

    task automatic setNote(input logic [7:0] x, input logic [7:0] y, input logic [7:0] life);
        note_valid = 1'b1; note_x = x; note_y = y; lifetime = life;
    endtask

    task automatic setHandL(input logic [7:0] x, input logic [7:0] y);
        hand_l_valid = 1'b1; hand_l_x = x; hand_l_y = y;
    endtask

    task automatic setHandR(input logic [7:0] x, input logic [7:0] y);
        hand_r_valid = 1'b1; hand_r_x = x; hand_r_y = y;
    endtask

    // Queue what the DUT must show after the next edge, then move to just past that edge.
    task automatic applyStimulus(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "slot_show", 32'(slot_show), 32'(e.show));
        cmp(e.tag, "score", 32'(score), 32'(e.score));
        cmp(e.tag, "combo", 32'(combo), 32'(e.combo));
        cmp(e.tag, "max_combo", 32'(max_combo), 32'(e.maxc));
        cmp(e.tag, "hit_pulse", 32'(hit_pulse), 32'(e.hit));
        cmp(e.tag, "miss_pulse", 32'(miss_pulse), 32'(e.miss));
        cmp(e.tag, "slot_pos", 32'(slot_pos[e.pidx*16 +: 16]), 32'(e.pos));
        cmp(e.tag, "hand_l_pos", 32'(hand_l_pos), 32'(e.hl));
        cmp(e.tag, "hand_r_pos", 32'(hand_r_pos), 32'(e.hr));
        cmp(e.tag, "sat_score", 32'(s_score), 32'(e.sat));
    endtask

    task automatic step(input exp_t e);
        applyStimulus(e);
        checkOutput();
        setIdle();
    endtask

    initial begin
        setIdle();
        lifetime  = '0;
        tolerance = 8'd2;
        rst       = 1'b1;
        step(mkExp("reset", 4'h0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0, 16'h0, 0));

        setNote(8'd10, 8'd3, 8'd0);
        step(mkExp("note0", 4'h1, 0, 0, 0, 0, 0, 0, 16'h0A03, 16'h0, 16'h0, 0));

        tolerance = 8'd1;
        setHandR(8'd11, 8'd12);
        step(mkExp("tol1_nohit", 4'h1, 0, 0, 0, 0, 0, 0, 16'h0A03, 16'h0, 16'h0B03, 0));

        tolerance = 8'd2;
        setHandR(8'd11, 8'd12);
        step(mkExp("tol2_hit", 4'h0, 5, 1, 1, 1, 0, 0, 16'h0A03, 16'h0, 16'h0B03, 5));

        step(mkExp("idle_hidden_pos", 4'h0, 5, 1, 1, 0, 0, 0, 16'h0A03, 16'h0, 16'h0, 5));

        setNote(8'd20, 8'd20, 8'd0);
        step(mkExp("fill0", 4'h1, 5, 1, 1, 0, 0, 0, 16'h1414, 16'h0, 16'h0, 5));
        setNote(8'd30, 8'd30, 8'd0);
        step(mkExp("fill1", 4'h3, 5, 1, 1, 0, 0, 1, 16'h1E1E, 16'h0, 16'h0, 5));
        setNote(8'd40, 8'd40, 8'd0);
        step(mkExp("fill2", 4'h7, 5, 1, 1, 0, 0, 2, 16'h2828, 16'h0, 16'h0, 5));
        setNote(8'd50, 8'd50, 8'd0);
        step(mkExp("fill3", 4'hF, 5, 1, 1, 0, 0, 3, 16'h3232, 16'h0, 16'h0, 5));

        setNote(8'd30, 8'd30, 8'd0);
        step(mkExp("duplicate", 4'hF, 5, 1, 1, 0, 0, 1, 16'h1E1E, 16'h0, 16'h0, 5));

        setNote(8'd60, 8'd60, 8'd0);
        step(mkExp("overwrite0", 4'hF, 5, 0, 1, 0, 1, 0, 16'h3C3C, 16'h0, 16'h0, 5));
        setNote(8'd70, 8'd70, 8'd0);
        step(mkExp("overwrite1", 4'hF, 5, 0, 1, 0, 1, 1, 16'h4646, 16'h0, 16'h0, 5));

        tolerance = 8'd0;
        setHandR(8'd50, 8'd221);
        step(mkExp("tol0_nohit", 4'hF, 5, 0, 1, 0, 0, 3, 16'h3232, 16'h0, 16'h3232, 5));

        tolerance = 8'd2;
        setHandL(8'd40, 8'd231);
        setHandR(8'd51, 8'd221);
        step(mkExp("two_hands", 4'h3, 15, 2, 2, 1, 0, 2, 16'h2828, 16'h2828, 16'h3332, 15));

        setNote(8'd80, 8'd80, 8'd3);
        step(mkExp("life3_note", 4'h7, 15, 2, 2, 0, 0, 2, 16'h5050, 16'h0, 16'h0, 15));
        tick = 1'b1;
        step(mkExp("tick1", 4'h7, 15, 2, 2, 0, 0, 2, 16'h5050, 16'h0, 16'h0, 15));
        tick = 1'b1;
        step(mkExp("tick2", 4'h7, 15, 2, 2, 0, 0, 2, 16'h5050, 16'h0, 16'h0, 15));
        tick = 1'b1;
        step(mkExp("tick3_expire", 4'h3, 15, 0, 2, 0, 1, 2, 16'h5050, 16'h0, 16'h0, 15));

        setNote(8'd90, 8'd90, 8'd3);
        step(mkExp("life3_again", 4'h7, 15, 0, 2, 0, 0, 2, 16'h5A5A, 16'h0, 16'h0, 15));
        tick = 1'b1;
        step(mkExp("tick1b", 4'h7, 15, 0, 2, 0, 0, 2, 16'h5A5A, 16'h0, 16'h0, 15));
        tick = 1'b1;
        step(mkExp("tick2b", 4'h7, 15, 0, 2, 0, 0, 2, 16'h5A5A, 16'h0, 16'h0, 15));
        tick = 1'b1;
        setHandR(8'd90, 8'd181);
        step(mkExp("hit_beats_expiry", 4'h3, 20, 1, 2, 1, 0, 2, 16'h5A5A, 16'h0, 16'h5A5A, 15));

        setNote(8'd100, 8'd100, 8'd1);
        step(mkExp("life1_note", 4'h7, 20, 1, 2, 0, 0, 2, 16'h6464, 16'h0, 16'h0, 15));
        tick = 1'b1;
        setHandL(8'd60, 8'd211);
        setHandR(8'd70, 8'd201);
        step(mkExp("hits_and_expiry", 4'h0, 30, 2, 2, 1, 1, 0, 16'h3C3C, 16'h3C3C, 16'h4646, 15));

        rst = 1'b1;
        setNote(8'd5, 8'd5, 8'd0);
        setHandL(8'd5, 8'd5);
        step(mkExp("reset_midgame", 4'h0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0, 16'h0, 0));
        step(mkExp("after_reset", 4'h0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0, 16'h0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
